amod_sync: RTL and testbench
============================

AMOD_SYNC -- requirements
Module: amod_sync

Interface
REQ-001 Parameter WIDTH, default 1: data bits per channel.
REQ-002 Parameter CH, default 1: number of independent channels.
REQ-003 Parameter MODE, default 0: 0 means the Q-feedback strobe is used; 1 means the A-only strobe is used.
REQ-004 Parameter CNT_W, default 8: width of each per-channel capture counter.
REQ-005 Port CLK, input, 1 bit: single clock; every flop samples on its rising edge.
REQ-006 Port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port A, input, CH bits: per-channel strobe-control input.
REQ-008 Port D, input, CH*WIDTH bits: capture data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port CLR, input, CH bits: synchronous per-channel counter clear.
REQ-010 Port Q, output, CH*WIDTH bits: captured data, registered, with the same packing as D.
REQ-011 Port VLD, output, CH bits: one-cycle pulse that is high in the cycle after Q[i] is loaded.
REQ-012 Port CNT, output, CH*CNT_W bits: per-channel capture count, registered.

Function
REQ-013 All logic SHALL be clocked only by CLK; no internal signal SHALL drive any clock or reset pin.
REQ-014 fb[i] SHALL equal the reduction OR of Q[i] when MODE=0, and SHALL be 0 when MODE=1.
REQ-015 On each CLK edge, the strobe register SHALL load s[i] <= ~(A[i] | fb[i]), and the delay register SHALL load s_d[i] <= s[i].
REQ-016 rise[i] SHALL be defined as s[i] & ~s_d[i]; both terms are registers, so rise[i] has no combinational path from A.
REQ-017 On a CLK edge with rise[i]=1, Q[i] SHALL load D[i] as sampled at that edge; when rise[i]=0, Q[i] SHALL hold.
REQ-018 Latency: if A[i] falls before edge k, s rises at edge k and Q[i] loads at edge k+1.
REQ-019 VLD[i] SHALL be 1 for exactly the one cycle after each Q[i] load, and 0 otherwise.
REQ-020 CNT[i] SHALL increment by 1 on each Q[i] load and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-021 When CLR[i] and a load of channel i occur on the same edge, CLR SHALL win and CNT[i] SHALL become 0; Q[i] and VLD[i] SHALL still update.
REQ-022 In MODE=0, a nonzero Q[i] forces s[i]=0, so no further capture occurs until Q[i] returns to 0 by reset.
REQ-023 In MODE=0, a capture of D[i]=0 SHALL leave the channel re-armable.
REQ-024 Channels SHALL be fully independent: no state is shared between channels.

Reset
REQ-025 While RST_N=0, Q, VLD and CNT SHALL be 0, and s and s_d SHALL be 1; assertion SHALL take effect immediately and asynchronously.
REQ-026 Because s and s_d reset to 1, the first cycle after reset release SHALL produce no capture.
REQ-027 Reset asserted mid-operation SHALL abort any pending capture, with no partial update visible.

Structure
REQ-028 Package amod_sync_pkg SHALL hold the constants MODE_FB=0 and MODE_NOFB=1 and the default widths.
REQ-029 Sub-module amod_sync_ch SHALL implement one channel (s, s_d, Q, VLD, CNT); amod_sync SHALL instantiate CH copies with generate.

Verification
REQ-030 Scenario 1 (MODE=0, WIDTH=1, CH=1): release reset with A=0 and D=1 -> no capture at edge 1; hold A=1 for 2 cycles, then set A=0 -> Q=1 and VLD pulse at edge k+1; further A toggles cause no capture while Q=1.
REQ-031 Scenario 2 (MODE=0): D=0 captured -> Q stays 0; the next A 1->0 transition captures D=1; CNT=2.
REQ-032 Scenario 3 (MODE=1, WIDTH=8): toggle A with period 4 cycles and D incrementing -> Q equals D sampled one edge after each s rise; CNT counts every toggle.
REQ-033 Scenario 4 (CNT_W=2): 5 captures -> CNT sequence 1,2,3,3,3; CLR coincident with a capture -> CNT=0, Q still loaded.
REQ-034 Scenario 5 (CH=4): stimulate only channel 2 -> only Q[2], VLD[2] and CNT[2] change; all other channels keep their reset values.
REQ-035 Scenario 6: assert RST_N mid-cycle while s has just risen -> Q, VLD and CNT are 0 immediately, and no capture occurs after release.

Source files
------------

// File: rtl/amod_sync_pkg.sv
// amod_sync_pkg: shared constants for the amod_sync strobe-capture block.
//   MODE_FB   : strobe is gated by feedback from the captured value
//   MODE_NOFB : strobe is driven from A only
//   DEF_*     : default parameter values for the top, interface and channel
package amod_sync_pkg;

  localparam int MODE_FB   = 0;
  localparam int MODE_NOFB = 1;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CH    = 1;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/amod_sync_if.sv
// amod_sync_if: bundles the per-channel control, data and status signals.
//   A   [CH]          strobe-control input, one bit per channel
//   D   [CH*WIDTH]    capture data, channel i at [i*WIDTH +: WIDTH]
//   CLR [CH]          synchronous per-channel counter clear
//   Q   [CH*WIDTH]    captured data, same packing as D
//   VLD [CH]          one-cycle pulse in the cycle after a capture
//   CNT [CH*CNT_W]    per-channel saturating capture count
// master: drives A/D/CLR and observes results. slave: the capture block.
interface amod_sync_if
  import amod_sync_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CH    = DEF_CH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic [CH-1:0]       A;
  logic [CH*WIDTH-1:0] D;
  logic [CH-1:0]       CLR;
  logic [CH*WIDTH-1:0] Q;
  logic [CH-1:0]       VLD;
  logic [CH*CNT_W-1:0] CNT;

  modport master (output A, D, CLR, input Q, VLD, CNT);
  modport slave  (input A, D, CLR, output Q, VLD, CNT);

endinterface

// File: rtl/amod_sync_ch.sv
// amod_sync_ch: one capture channel.
//   CLK, RST_N : clock and async active-low reset
//   a          : strobe-control input
//   d          : data to capture
//   clr        : synchronous counter clear (wins over a same-edge capture)
//   q          : captured data
//   vld        : pulse in the cycle after q is loaded
//   cnt        : saturating capture count
// The strobe is registered and edge-detected against its own delayed copy,
// so a capture happens one edge after the strobe register rises.
module amod_sync_ch
  import amod_sync_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MODE  = MODE_FB,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             a,
  input  logic [WIDTH-1:0] d,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             vld,
  output logic [CNT_W-1:0] cnt
);

  logic             strobe_q, strobe_d;
  logic             strobe_dly_q, strobe_dly_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fb;
  logic             rise;

  always_comb begin
    // In feedback mode a nonzero captured value holds the strobe low,
    // locking the channel until reset.
    fb           = (MODE == MODE_FB) ? (|data_q) : 1'b0;
    rise         = strobe_q & ~strobe_dly_q;
    strobe_d     = ~(a | fb);
    strobe_dly_d = strobe_q;
    data_d       = rise ? d : data_q;
    vld_d        = rise;
    cnt_d        = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (rise && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Strobe and its delay reset high so release never looks like a rising edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      strobe_q     <= 1'b1;
      strobe_dly_q <= 1'b1;
      data_q       <= '0;
      vld_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      strobe_q     <= strobe_d;
      strobe_dly_q <= strobe_dly_d;
      data_q       <= data_d;
      vld_q        <= vld_d;
      cnt_q        <= cnt_d;
    end
  end

  assign q   = data_q;
  assign vld = vld_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/amod_sync.sv
// amod_sync: CH independent strobe-capture channels.
//   CLK, RST_N : clock and async active-low reset
//   bus        : amod_sync_if slave (A, D, CLR in; Q, VLD, CNT out)
// Parameters: WIDTH data bits per channel, CH channels, MODE strobe select
// (MODE_FB / MODE_NOFB), CNT_W counter width.
module amod_sync
  import amod_sync_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CH    = DEF_CH,
  parameter int MODE  = MODE_FB,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic        CLK,
  input logic        RST_N,
  amod_sync_if.slave bus
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    amod_sync_ch #(
      .WIDTH (WIDTH),
      .MODE  (MODE),
      .CNT_W (CNT_W)
    ) u_ch (
      .CLK   (CLK),
      .RST_N (RST_N),
      .a     (bus.A[i]),
      .d     (bus.D[i*WIDTH +: WIDTH]),
      .clr   (bus.CLR[i]),
      .q     (bus.Q[i*WIDTH +: WIDTH]),
      .vld   (bus.VLD[i]),
      .cnt   (bus.CNT[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_amod_sync.sv
// tb_amod_sync: directed bench for amod_sync. Four DUT configurations share
// one clock and one reset:
//   u0: MODE=0, WIDTH=1, CH=1, CNT_W=8
//   u1: MODE=1, WIDTH=8, CH=1, CNT_W=8
//   u2: MODE=1, WIDTH=1, CH=1, CNT_W=2
//   u3: MODE=1, WIDTH=4, CH=4, CNT_W=8
module tb_amod_sync;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  amod_sync_if #(.WIDTH(1), .CH(1), .CNT_W(8)) b0 ();
  amod_sync_if #(.WIDTH(8), .CH(1), .CNT_W(8)) b1 ();
  amod_sync_if #(.WIDTH(1), .CH(1), .CNT_W(2)) b2 ();
  amod_sync_if #(.WIDTH(4), .CH(4), .CNT_W(8)) b3 ();

  amod_sync #(.WIDTH(1), .CH(1), .MODE(0), .CNT_W(8)) u0 (.CLK(clk), .RST_N(rst_n), .bus(b0));
  amod_sync #(.WIDTH(8), .CH(1), .MODE(1), .CNT_W(8)) u1 (.CLK(clk), .RST_N(rst_n), .bus(b1));
  amod_sync #(.WIDTH(1), .CH(1), .MODE(1), .CNT_W(2)) u2 (.CLK(clk), .RST_N(rst_n), .bus(b2));
  amod_sync #(.WIDTH(4), .CH(4), .MODE(1), .CNT_W(8)) u3 (.CLK(clk), .RST_N(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic idle_all;
    b0.A = '0; b0.D = '0; b0.CLR = '0;
    b1.A = '0; b1.D = '0; b1.CLR = '0;
    b2.A = '0; b2.D = '0; b2.CLR = '0;
    b3.A = '0; b3.D = '0; b3.CLR = '0;
  endtask

  task automatic test_reset;
    idle_all;
    b0.D = 1'b1;
    b3.D = 16'hFFFF;
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({b0.Q, b0.VLD, b0.CNT} !== 10'h000) begin
      n_bad++; $display("FAIL reset_u0: got %h want %h", {b0.Q, b0.VLD, b0.CNT}, 10'h000);
    end
    n_cmp++;
    if ({b1.Q, b1.VLD, b1.CNT} !== 17'h00000) begin
      n_bad++; $display("FAIL reset_u1: got %h want %h", {b1.Q, b1.VLD, b1.CNT}, 17'h00000);
    end
    n_cmp++;
    if ({b3.Q, b3.VLD, b3.CNT} !== 52'h0) begin
      n_bad++; $display("FAIL reset_u3: got %h want %h", {b3.Q, b3.VLD, b3.CNT}, 52'h0);
    end
  endtask

  task automatic test_fb_first_capture;
    idle_all;
    b0.D = 1'b1;
    do_reset;
    tick;
    n_cmp++;
    if ({b0.Q, b0.VLD} !== 2'b00) begin
      n_bad++; $display("FAIL s1_edge1: got %b want %b", {b0.Q, b0.VLD}, 2'b00);
    end
    b0.A = 1'b1;
    tick;
    tick;
    b0.A = 1'b0;
    tick;
    n_cmp++;
    if ({b0.Q, b0.VLD} !== 2'b00) begin
      n_bad++; $display("FAIL s1_edge_k: got %b want %b", {b0.Q, b0.VLD}, 2'b00);
    end
    tick;
    n_cmp++;
    if ({b0.Q, b0.VLD, b0.CNT} !== {1'b1, 1'b1, 8'd1}) begin
      n_bad++; $display("FAIL s1_capture: got %h want %h", {b0.Q, b0.VLD, b0.CNT}, {1'b1, 1'b1, 8'd1});
    end
    for (int i = 0; i < 3; i++) begin
      b0.A = 1'b1;
      tick;
      tick;
      b0.A = 1'b0;
      tick;
      tick;
      n_cmp++;
      if ({b0.Q, b0.VLD, b0.CNT} !== {1'b1, 1'b0, 8'd1}) begin
        n_bad++; $display("FAIL s1_locked_%0d: got %h want %h", i, {b0.Q, b0.VLD, b0.CNT}, {1'b1, 1'b0, 8'd1});
      end
    end
  endtask

  task automatic test_zero_rearm;
    idle_all;
    do_reset;
    tick;
    b0.A = 1'b1;
    tick;
    tick;
    b0.A = 1'b0;
    tick;
    tick;
    n_cmp++;
    if ({b0.Q, b0.VLD, b0.CNT} !== {1'b0, 1'b1, 8'd1}) begin
      n_bad++; $display("FAIL s2_zero_cap: got %h want %h", {b0.Q, b0.VLD, b0.CNT}, {1'b0, 1'b1, 8'd1});
    end
    b0.D = 1'b1;
    b0.A = 1'b1;
    tick;
    tick;
    b0.A = 1'b0;
    tick;
    n_cmp++;
    if ({b0.Q, b0.VLD} !== 2'b00) begin
      n_bad++; $display("FAIL s2_pre_cap: got %b want %b", {b0.Q, b0.VLD}, 2'b00);
    end
    tick;
    n_cmp++;
    if ({b0.Q, b0.VLD, b0.CNT} !== {1'b1, 1'b1, 8'd2}) begin
      n_bad++; $display("FAIL s2_rearm_cap: got %h want %h", {b0.Q, b0.VLD, b0.CNT}, {1'b1, 1'b1, 8'd2});
    end
  endtask

  task automatic test_strobe_toggle;
    logic [7:0] exp_q;
    logic       exp_v;
    logic [7:0] exp_c;
    idle_all;
    do_reset;
    // A high for two edges, low for two; s rises at edges 3,7,11 and
    // data driven before edges 4,8,12 is captured.
    for (int c = 1; c <= 12; c++) begin
      b1.A = (((c - 1) / 2) % 2 == 0) ? 1'b1 : 1'b0;
      b1.D = 8'(8'h10 + c);
      tick;
      exp_q = (c < 4) ? 8'h00 : 8'(8'h10 + (c / 4) * 4);
      exp_v = (c % 4 == 0);
      exp_c = 8'(c / 4);
      n_cmp++;
      if ({b1.Q, b1.VLD, b1.CNT} !== {exp_q, exp_v, exp_c}) begin
        n_bad++; $display("FAIL s3_edge_%0d: got %h want %h", c, {b1.Q, b1.VLD, b1.CNT}, {exp_q, exp_v, exp_c});
      end
    end
  endtask

  task automatic test_cnt_sat_clr;
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    idle_all;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      b2.D = 1'(i % 2);
      b2.A = 1'b1;
      tick;
      b2.A = 1'b0;
      tick;
      tick;
      n_cmp++;
      if ({b2.Q, b2.VLD, b2.CNT} !== {1'(i % 2), 1'b1, exp_cnt[i]}) begin
        n_bad++; $display("FAIL s4_cap_%0d: got %h want %h", i, {b2.Q, b2.VLD, b2.CNT}, {1'(i % 2), 1'b1, exp_cnt[i]});
      end
    end
    b2.D = 1'b1;
    b2.A = 1'b1;
    tick;
    b2.A = 1'b0;
    tick;
    b2.CLR = 1'b1;
    tick;
    b2.CLR = 1'b0;
    n_cmp++;
    if ({b2.Q, b2.VLD, b2.CNT} !== {1'b1, 1'b1, 2'd0}) begin
      n_bad++; $display("FAIL s4_clr_win: got %h want %h", {b2.Q, b2.VLD, b2.CNT}, {1'b1, 1'b1, 2'd0});
    end
    b2.D = 1'b0;
    b2.A = 1'b1;
    tick;
    b2.A = 1'b0;
    tick;
    tick;
    n_cmp++;
    if ({b2.Q, b2.VLD, b2.CNT} !== {1'b0, 1'b1, 2'd1}) begin
      n_bad++; $display("FAIL s4_after_clr: got %h want %h", {b2.Q, b2.VLD, b2.CNT}, {1'b0, 1'b1, 2'd1});
    end
  endtask

  task automatic test_channel_isolation;
    idle_all;
    b3.D = 16'hABCD;
    do_reset;
    tick;
    b3.A = 4'b0100;
    tick;
    b3.A = 4'b0000;
    tick;
    n_cmp++;
    if ({b3.Q, b3.VLD} !== {16'h0000, 4'b0000}) begin
      n_bad++; $display("FAIL s5_pre_cap: got %h want %h", {b3.Q, b3.VLD}, {16'h0000, 4'b0000});
    end
    tick;
    n_cmp++;
    if ({b3.Q, b3.VLD, b3.CNT} !== {16'h0B00, 4'b0100, 32'h0001_0000}) begin
      n_bad++; $display("FAIL s5_ch2_cap: got %h want %h", {b3.Q, b3.VLD, b3.CNT}, {16'h0B00, 4'b0100, 32'h0001_0000});
    end
    tick;
    n_cmp++;
    if ({b3.Q, b3.VLD, b3.CNT} !== {16'h0B00, 4'b0000, 32'h0001_0000}) begin
      n_bad++; $display("FAIL s5_ch2_hold: got %h want %h", {b3.Q, b3.VLD, b3.CNT}, {16'h0B00, 4'b0000, 32'h0001_0000});
    end
  endtask

  task automatic test_reset_mid_capture;
    idle_all;
    b2.D = 1'b1;
    do_reset;
    tick;
    b2.A = 1'b1;
    tick;
    b2.A = 1'b0;
    tick;
    tick;
    n_cmp++;
    if ({b2.Q, b2.CNT} !== {1'b1, 2'd1}) begin
      n_bad++; $display("FAIL s6_setup: got %h want %h", {b2.Q, b2.CNT}, {1'b1, 2'd1});
    end
    b2.A = 1'b1;
    tick;
    b2.A = 1'b0;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({b2.Q, b2.VLD, b2.CNT} !== {1'b0, 1'b0, 2'd0}) begin
      n_bad++; $display("FAIL s6_async_clear: got %h want %h", {b2.Q, b2.VLD, b2.CNT}, {1'b0, 1'b0, 2'd0});
    end
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if ({b2.Q, b2.VLD, b2.CNT} !== {1'b0, 1'b0, 2'd0}) begin
        n_bad++; $display("FAIL s6_no_cap_%0d: got %h want %h", i, {b2.Q, b2.VLD, b2.CNT}, {1'b0, 1'b0, 2'd0});
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    test_reset;
    test_fb_first_capture;
    test_zero_rearm;
    test_strobe_toggle;
    test_cnt_sat_clr;
    test_channel_isolation;
    test_reset_mid_capture;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
